ps2_scancode_decoder: RTL
=========================

Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 receiver. Consumes its validated 8-bit frames: rx_data is the frame payload, rx_valid is the 1-cycle good-frame strobe.
- Assembles Set-2 scan-code sequences (E0 extended prefix, F0 break prefix, E1 Pause sequence) into single key events.
- Queues events in a small FIFO with a valid/ready interface for the display/ASCII stage.
- Also provides a make-event counter and sequence-error and overflow flags.

Parameters:
- FIFO_DEPTH, 8, number of event entries; power of 2, minimum 2.
- TIMEOUT_CYC, 2500000, idle clk cycles allowed between prefix byte and its follow-on byte before the sequence is abandoned.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- rx_data  in  8  received scan byte; valid only with rx_valid
- rx_valid  in  1  single-cycle strobe, one per received byte
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts head when ev_valid & ev_ready
- ev_code  out  8  head event scan code
- ev_ext  out  1  head event had E0 prefix
- ev_break  out  1  head event is a key release
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count
- overflow  out  1  sticky: event dropped because FIFO full
- ovf_clr  in  1  clears overflow
- seq_err  out  1  1-cycle pulse on prefix timeout
- press_count  out  8  make events pushed into FIFO, wraps 255->0

Behaviour:
- Reset values (async, resetn=0):
  - ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, fifo_level=0, overflow=0, seq_err=0, press_count=0.
  - FSM in IDLE, timeout counter 0, pointers 0.
- FSM advances only on cycles with rx_valid=1. States: IDLE, E0, F0, E0F0, PAUSE.
- IDLE:
  - E0 -> E0; F0 -> F0; E1 -> PAUSE, skip counter loaded with 7.
  - 00, AA, FA, FE, FF -> ignored, stay IDLE.
  - Any other byte -> emit make {code,ext=0}.
- E0:
  - F0 -> E0F0; E0 -> stay E0.
  - 12 -> drop, go IDLE (fake shift).
  - Other byte -> emit make ext=1, go IDLE.
- F0: any byte -> emit break ext=0, go IDLE.
- E0F0: 12 -> drop, go IDLE; other byte -> emit break ext=1, go IDLE.
- PAUSE:
  - Each byte decrements the skip counter.
  - When the counter reaches 0 on the 7th byte: emit make {code=E1, ext=0}, go IDLE.
  - No break event is ever generated for Pause.
- Timeout:
  - In E0, F0, E0F0 or PAUSE, a counter increments every cycle without rx_valid and clears on rx_valid.
  - Reaching TIMEOUT_CYC-1: go IDLE, pulse seq_err for 1 cycle, no event emitted.
  - Counter held at 0 in IDLE.
- Latency:
  - rx_valid at cycle N -> push into FIFO at edge N+1.
  - If FIFO was empty, ev_valid=1 with the event from cycle N+2.
  - ev_* outputs are registered.
- FIFO behaviour:
  - First-word fall-through; ev_code/ev_ext/ev_break stable while ev_valid & !ev_ready.
  - Pop on ev_valid & ev_ready.
  - Push while full with no pop in the same cycle: event dropped, overflow<=1, press_count unchanged.
  - Push while full with a simultaneous pop: both happen, level unchanged, no overflow.
  - Push and pop on an empty FIFO: push only.
- ovf_clr clears overflow; a drop in the same cycle wins (overflow stays 1).
- press_count increments by 1 on each successful push of a make event; modulo 256.
- Back-to-back rx_valid on consecutive cycles must be handled.

Optional Feature:
- Macro: TYPEMATIC_FILTER_EN.
- Defined:
  - Register last_make {valid,ext,code}.
  - A make event equal to last_make while valid=1 is suppressed: no push, no press_count increment.
  - A break whose {ext,code} matches clears valid.
  - Any other make overwrites last_make.
  - Reset clears valid.
- Undefined: every make is forwarded, including typematic repeats; no last_make register.

Test Plan:
- Bytes 1C, F0, 1C with ev_ready=1 -> events {1C,ext0,make} then {1C,ext0,break}; press_count=1.
- Bytes E0, 75, E0, F0, 75 -> {75,ext1,make}, {75,ext1,break}.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,ext0,make}.
- Bytes E0 12 E0 7C -> exactly one event {7C,ext1,make}.
- ev_ready=0, FIFO_DEPTH=8, push 9 make codes 15..1D:
  - fifo_level=8, overflow=1, press_count=8, head=15.
  - ovf_clr -> overflow=0.
  - Drain yields 15..1C in order.
- F0 then no byte for TIMEOUT_CYC cycles (TIMEOUT_CYC=100 in bench) -> one seq_err pulse, FSM in IDLE; next byte 1C decodes as make.
- 1C, 1C, 1C (typematic):
  - With TYPEMATIC_FILTER_EN, 1 event, press_count=1.
  - Without it, 3 events, press_count=3.
- Assert resetn mid-sequence after E0 -> all outputs at reset values immediately; next byte 75 decodes as ext=0 make.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan-code assembler (E0/F0/E1 sequences) feeding a small FWFT event FIFO.
// Optional build macro TYPEMATIC_FILTER_EN suppresses repeated makes of a held key.
module ps2_scancode_decoder #(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned TIMEOUT_CYC = 2500000
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [7:0]                    rx_data,
   input  logic                          rx_valid,
   output logic                          ev_valid,
   input  logic                          ev_ready,
   output logic [7:0]                    ev_code,
   output logic                          ev_ext,
   output logic                          ev_break,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          ovf_clr,
   output logic                          seq_err,
   output logic [7:0]                    press_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {StIdle, StE0, StF0, StE0F0, StPause} state_e;

   state_e        state_q, state_d;
   logic [2:0]    skip_q, skip_d;
   logic [TW-1:0] tmo_q;
   logic          req, req_ext, req_brk, suppress;
   logic [7:0]    req_code;
   logic          emit_q, emit_ext_q, emit_brk_q, seq_err_q;
   logic [7:0]    emit_code_q;

   always_comb begin
      state_d  = state_q;
      skip_d   = skip_q;
      req      = 1'b0;
      req_code = rx_data;
      req_ext  = 1'b0;
      req_brk  = 1'b0;
      unique case (state_q)
         StIdle: begin
            case (rx_data)
               8'hE0: state_d = StE0;
               8'hF0: state_d = StF0;
               8'hE1: begin
                  state_d = StPause;
                  skip_d  = 3'd7;
               end
               8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: state_d = StIdle;
               default: req = 1'b1;
            endcase
         end
         StE0: begin
            if (rx_data == 8'hF0) begin
               state_d = StE0F0;
            end else if (rx_data != 8'hE0) begin
               state_d = StIdle;
               // E0 12 is a fake shift and never becomes an event
               req     = (rx_data != 8'h12);
               req_ext = 1'b1;
            end
         end
         StF0: begin
            state_d = StIdle;
            req     = 1'b1;
            req_brk = 1'b1;
         end
         StE0F0: begin
            state_d = StIdle;
            req     = (rx_data != 8'h12);
            req_ext = 1'b1;
            req_brk = 1'b1;
         end
         StPause: begin
            skip_d = skip_q - 3'd1;
            if (skip_q == 3'd1) begin
               state_d  = StIdle;
               req      = 1'b1;
               req_code = 8'hE1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef TYPEMATIC_FILTER_EN
   logic       lm_valid_q, lm_ext_q, lm_match;
   logic [7:0] lm_code_q;

   assign lm_match = (lm_ext_q == req_ext) && (lm_code_q == req_code);
   assign suppress = req && !req_brk && lm_valid_q && lm_match;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lm_valid_q <= 1'b0;
         lm_ext_q   <= 1'b0;
         lm_code_q  <= 8'h00;
      end else if (rx_valid && req) begin
         if (req_brk) begin
            if (lm_match) lm_valid_q <= 1'b0;
         end else if (!suppress) begin
            lm_valid_q <= 1'b1;
            lm_ext_q   <= req_ext;
            lm_code_q  <= req_code;
         end
      end
   end
`else
   assign suppress = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= StIdle;
         skip_q      <= 3'd0;
         tmo_q       <= '0;
         emit_q      <= 1'b0;
         emit_code_q <= 8'h00;
         emit_ext_q  <= 1'b0;
         emit_brk_q  <= 1'b0;
         seq_err_q   <= 1'b0;
      end else begin
         emit_q    <= 1'b0;
         seq_err_q <= 1'b0;
         if (rx_valid) begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            tmo_q       <= '0;
            emit_q      <= req && !suppress;
            emit_code_q <= req_code;
            emit_ext_q  <= req_ext;
            emit_brk_q  <= req_brk;
         end else if (state_q != StIdle) begin
            if (tmo_q == TMO_LAST) begin
               state_q   <= StIdle;
               tmo_q     <= '0;
               seq_err_q <= 1'b1;
            end else begin
               tmo_q <= tmo_q + TW'(1);
            end
         end
      end
   end

   assign seq_err = seq_err_q;

   // Event FIFO: entry = {break, ext, code}
   logic [9:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          ev_valid_q, overflow_q, full, pop, push_ok, drop;
   logic [7:0]    press_q;

   assign full    = (cnt_q == FULL_LVL);
   assign pop     = ev_valid_q && ev_ready;
   assign push_ok = emit_q && (!full || pop);
   assign drop    = emit_q && full && !pop;
   assign cnt_d   = cnt_q + (AW + 1)'(push_ok) - (AW + 1)'(pop);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         ev_valid_q <= 1'b0;
         overflow_q <= 1'b0;
         press_q    <= 8'h00;
      end else begin
         if (push_ok) begin
            mem_q[wptr_q] <= {emit_brk_q, emit_ext_q, emit_code_q};
            wptr_q        <= wptr_q + AW'(1);
            if (!emit_brk_q) press_q <= press_q + 8'd1;
         end
         if (pop) rptr_q <= rptr_q + AW'(1);
         cnt_q      <= cnt_d;
         ev_valid_q <= (cnt_d != '0);
         if (drop)         overflow_q <= 1'b1;
         else if (ovf_clr) overflow_q <= 1'b0;
      end
   end

   assign ev_valid    = ev_valid_q;
   assign ev_code     = mem_q[rptr_q][7:0];
   assign ev_ext      = mem_q[rptr_q][8];
   assign ev_break    = mem_q[rptr_q][9];
   assign fifo_level  = cnt_q;
   assign overflow    = overflow_q;
   assign press_count = press_q;

endmodule
